// File: rtl/cnn_layer_accel_result_packer.sv
// rtl/cnn_layer_accel_result_packer.sv - packs 16-bit quad results into 128-bit words behind a small output FIFO
module cnn_layer_accel_result_packer #(
  parameter int C_RESULT_WIDTH = 16,
  parameter int C_OUT_WIDTH    = 128,
  parameter int C_FIFO_DEPTH   = 4
) (
  input  logic                                    clk_if,
  input  logic                                    rst,
  input  logic                                    job_start,
  input  logic [9:0]                              num_output_rows_cfg,
  input  logic [9:0]                              num_output_cols_cfg,
  input  logic [11:0]                             num_kernel_cfg,
  input  logic                                    result_valid,
  output logic                                    result_accept,
  input  logic [C_RESULT_WIDTH-1:0]               result_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [C_OUT_WIDTH-1:0]                  out_data,
  output logic [C_OUT_WIDTH/C_RESULT_WIDTH-1:0]   out_keep,
  output logic                                    out_last,
  output logic                                    job_done,
  output logic                                    busy
);

  localparam int LANES = C_OUT_WIDTH / C_RESULT_WIDTH;
  localparam int LW    = $clog2(LANES);
  localparam int AW    = $clog2(C_FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state, state_next;
  logic [31:0]          total, res_cnt;
  logic [LW-1:0]        lane_idx;
  logic [C_OUT_WIDTH-1:0] asm_data, asm_data_next;
  logic [LANES-1:0]     asm_keep, asm_keep_next;

  logic [C_OUT_WIDTH-1:0] fifo_data [C_FIFO_DEPTH];
  logic [LANES-1:0]       fifo_keep [C_FIFO_DEPTH];
  logic [C_FIFO_DEPTH-1:0] fifo_last;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          fifo_count;

  logic start_ok, cfg_zero, accept_fire, is_final, push, pop;

  assign start_ok      = (state == S_IDLE) && job_start;
  assign cfg_zero      = (num_output_rows_cfg == '0) || (num_output_cols_cfg == '0) ||
                         (num_kernel_cfg == '0);
  assign result_accept = (state == S_RUN) && (fifo_count < CW'(C_FIFO_DEPTH));
  assign accept_fire   = result_valid && result_accept;
  assign is_final      = accept_fire && ((res_cnt + 32'd1) == total);
  assign push          = accept_fire && ((lane_idx == LW'(LANES - 1)) || is_final);
  assign pop           = out_valid && out_ready;

  // FIFO head drives the outputs; an empty FIFO presents all-zero fields
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_keep  = out_valid ? fifo_keep[rd_ptr] : '0;
  assign out_last  = out_valid ? fifo_last[rd_ptr] : 1'b0;
  assign job_done  = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // Word being assembled with the incoming result merged into its lane
  always_comb begin
    asm_data_next = asm_data;
    asm_keep_next = asm_keep | (LANES'(1) << lane_idx);
    asm_data_next[lane_idx*C_RESULT_WIDTH +: C_RESULT_WIDTH] = result_data;
  end

  // State register
  always_ff @(posedge clk_if) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state: final word push ends RUN, final word handshake ends DRAIN
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (job_start) state_next = cfg_zero ? S_DONE : S_RUN;
      S_RUN:   if (is_final) state_next = S_DRAIN;
      S_DRAIN: if ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Job configuration, result counter and lane assembly
  always_ff @(posedge clk_if) begin
    if (!rst) begin
      total    <= '0;
      res_cnt  <= '0;
      lane_idx <= '0;
      asm_data <= '0;
      asm_keep <= '0;
    end else if (start_ok) begin
      total    <= 32'(num_output_rows_cfg) * 32'(num_output_cols_cfg) * 32'(num_kernel_cfg);
      res_cnt  <= '0;
      lane_idx <= '0;
      asm_data <= '0;
      asm_keep <= '0;
    end else if (accept_fire) begin
      res_cnt <= res_cnt + 32'd1;
      if (push) begin
        lane_idx <= '0;
        asm_data <= '0;
        asm_keep <= '0;
      end else begin
        lane_idx <= lane_idx + LW'(1);
        asm_data <= asm_data_next;
        asm_keep <= asm_keep_next;
      end
    end
  end

  // FIFO storage; contents are only observed through a nonzero count
  always_ff @(posedge clk_if) begin
    if (push) begin
      fifo_data[wr_ptr] <= asm_data_next;
      fifo_keep[wr_ptr] <= asm_keep_next;
      fifo_last[wr_ptr] <= is_final;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_if) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// tb/tb_cnn_layer_accel_result_packer.sv - self-checking bench for the result packer
module tb_cnn_layer_accel_result_packer;

  logic         clk_if = 1'b0;
  logic         rst = 1'b0;
  logic         job_start = 1'b0;
  logic [9:0]   num_output_rows_cfg = '0;
  logic [9:0]   num_output_cols_cfg = '0;
  logic [11:0]  num_kernel_cfg = '0;
  logic         result_valid = 1'b0;
  logic         result_accept;
  logic [15:0]  result_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [7:0]   out_keep;
  logic         out_last;
  logic         job_done;
  logic         busy;

  cnn_layer_accel_result_packer dut (
    .clk_if(clk_if), .rst(rst), .job_start(job_start),
    .num_output_rows_cfg(num_output_rows_cfg), .num_output_cols_cfg(num_output_cols_cfg),
    .num_kernel_cfg(num_kernel_cfg),
    .result_valid(result_valid), .result_accept(result_accept), .result_data(result_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .job_done(job_done), .busy(busy)
  );

  always #5 clk_if = ~clk_if;

  int checks = 0;
  int errors = 0;

  // expected words in order, and words actually handshaken
  logic [127:0] exp_data[$];
  logic [7:0]   exp_keep[$];
  logic         exp_last[$];
  logic [127:0] log_data[$];
  logic [7:0]   log_keep[$];
  logic         log_last[$];

  logic         done_due = 1'b0;
  logic         zero_mode = 1'b0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic [7:0]   prev_keep;
  logic         prev_last;
  int           acc_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: results base+i, i=0..n-1, grouped eight to a word, first result in lane 0
  task automatic expect_job(input int n, input logic [15:0] base);
    int nw;
    nw = (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      logic [127:0] d;
      logic [7:0]   k;
      d = '0;
      k = '0;
      for (int l = 0; l < 8; l++) begin
        if (w * 8 + l < n) begin
          d[l*16 +: 16] = base + 16'(w * 8 + l);
          k[l] = 1'b1;
        end
      end
      exp_data.push_back(d);
      exp_keep.push_back(k);
      exp_last.push_back(w == nw - 1);
    end
  endtask

  always @(posedge clk_if) if (rst && result_valid && result_accept) acc_cnt++;

  // Compare process: every handshake against the model, stability under stall, job_done timing
  always @(negedge clk_if) begin
    if (!rst) begin
      done_due   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (!zero_mode) chk("job_done_timing", {127'd0, job_done}, {127'd0, done_due});
      done_due = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", {127'd0, out_valid}, 128'd1);
        chk("stall_data", out_data, prev_data);
        chk("stall_keep_last", {119'd0, out_keep, out_last}, {119'd0, prev_keep, prev_last});
      end
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%h required=none", out_data);
        end else begin
          chk("word_data", out_data, exp_data.pop_front());
          chk("word_keep", {120'd0, out_keep}, {120'd0, exp_keep.pop_front()});
          chk("word_last", {127'd0, out_last}, {127'd0, exp_last.pop_front()});
        end
        log_data.push_back(out_data);
        log_keep.push_back(out_keep);
        log_last.push_back(out_last);
        done_due = out_last;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_keep  = out_keep;
      prev_last  = out_last;
    end
  end

  task automatic clear_logs();
    log_data.delete();
    log_keep.delete();
    log_last.delete();
  endtask

  task automatic start_job(input int r, input int c, input int k);
    num_output_rows_cfg = 10'(r);
    num_output_cols_cfg = 10'(c);
    num_kernel_cfg      = 12'(k);
    job_start = 1'b1;
    @(negedge clk_if);
    job_start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the result was taken
  task automatic send(input logic [15:0] v);
    int t;
    t = 0;
    result_valid = 1'b1;
    result_data  = v;
    while (!result_accept && t < 300) begin
      @(negedge clk_if);
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stuck required=accept value=%h", v);
    end else begin
      @(negedge clk_if);
    end
    result_valid = 1'b0;
  endtask

  task automatic send_range(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) send(base + 16'(i));
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!job_done && t < 400) begin
      @(negedge clk_if);
      t++;
    end
    chk("job_done_seen", {127'd0, job_done}, 128'd1);
    @(negedge clk_if);
    chk("idle_after_done", {126'd0, busy, job_done}, 128'd0);
    chk("model_drained", 128'(exp_data.size()), 128'd0);
  endtask

  task automatic chk_reset_values(input string nm);
    chk(nm, {out_data, out_keep, result_accept, out_valid, out_last, job_done, busy}, '0);
  endtask

  initial begin
    int base_acc;
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base_acc;
    repeat (3) @(negedge clk_if);
    chk_reset_values("reset_values");
    chk("reset_data", out_data, 128'd0);
    rst = 1'b1;
    @(negedge clk_if);

    // 4x4x1, results 0..15
    clear_logs();
    expect_job(16, 16'h0000);
    start_job(4, 4, 1);
    chk("busy_run", {127'd0, busy}, 128'd1);
    send_range(16, 16'h0000);
    wait_done();
    chk("t1_words", 128'(log_data.size()), 128'd2);
    chk("t1_w0_data", log_data[0], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("t1_w0_keep_last", {119'd0, log_keep[0], log_last[0]}, {119'd0, 8'hFF, 1'b0});
    chk("t1_w1_data", log_data[1], 128'h000F_000E_000D_000C_000B_000A_0009_0008);
    chk("t1_w1_keep_last", {119'd0, log_keep[1], log_last[1]}, {119'd0, 8'hFF, 1'b1});

    // 3x3x1, partial final word
    clear_logs();
    expect_job(9, 16'h0A00);
    start_job(3, 3, 1);
    send_range(9, 16'h0A00);
    wait_done();
    chk("t2_words", 128'(log_data.size()), 128'd2);
    chk("t2_w1_data", log_data[1], 128'h0000_0000_0000_0000_0000_0000_0000_0A08);
    chk("t2_w1_keep_last", {119'd0, log_keep[1], log_last[1]}, {119'd0, 8'h01, 1'b1});

    // Backpressure 8x8x1
    clear_logs();
    expect_job(64, 16'h0100);
    out_ready = 1'b0;
    start_job(8, 8, 1);
    base_acc = acc_cnt;
    fork
      send_range(64, 16'h0100);
      begin
        repeat (50) @(negedge clk_if);
        chk("bp_accepted", 128'(acc_cnt - base_acc), 128'd32);
        chk("bp_accept_low", {127'd0, result_accept}, 128'd0);
        out_ready = 1'b1;
      end
    join
    wait_done();
    chk("bp_words", 128'(log_data.size()), 128'd8);
    chk("bp_w7_data", log_data[7], 128'h013F_013E_013D_013C_013B_013A_0139_0138);

    // Zero configuration
    clear_logs();
    zero_mode = 1'b1;
    start_job(5, 5, 0);
    chk("zero_done", {126'd0, job_done, busy}, 128'd3);
    @(negedge clk_if);
    chk("zero_idle", {126'd0, job_done, busy}, 128'd0);
    zero_mode = 1'b0;
    chk("zero_no_words", 128'(log_data.size()), 128'd0);

    // job_start during RUN with a larger configuration is ignored
    clear_logs();
    expect_job(16, 16'h0200);
    start_job(4, 4, 1);
    send_range(3, 16'h0200);
    start_job(8, 8, 4);
    send_range(13, 16'h0203);
    wait_done();
    chk("ign_words", 128'(log_data.size()), 128'd2);

    // Reset mid-job after five results, then a 2x2x2 job
    clear_logs();
    start_job(4, 4, 1);
    send_range(5, 16'h0300);
    rst = 1'b0;
    @(negedge clk_if);
    chk_reset_values("midrst_values");
    rst = 1'b1;
    @(negedge clk_if);
    chk_reset_values("midrst_after");
    expect_job(8, 16'h0400);
    start_job(2, 2, 2);
    send_range(8, 16'h0400);
    wait_done();
    chk("rst_words", 128'(log_data.size()), 128'd1);
    chk("rst_w0_keep_last", {119'd0, log_keep[0], log_last[0]}, {119'd0, 8'hFF, 1'b1});
    chk("rst_w0_data", log_data[0], 128'h0407_0406_0405_0404_0403_0402_0401_0400);

    repeat (3) @(negedge clk_if);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
